sme_driver: RTL and testbench
=============================

# sme_driver

Host-side transmitter for the string-matching engine (SME) character interface. It buffers one target string (up to 32 chars) and one pattern (up to 8 chars) written by a host. On command it streams them to the engine on `chardata`/`isstring`/`ispattern`, then waits for the engine's `valid` and captures `match`/`match_index` into result registers. It sits between the test/host controller and the SME and owns every cycle of that protocol.

## Interface
Parameters:
- `STR_MAX`, 32: string buffer depth, in chars.
- `PAT_MAX`, 8: pattern buffer depth, in chars.
- `TIMEOUT`, 1023: maximum number of WAIT cycles before the transaction is abandoned.

Ports:
- `clk`  in  1  the single clock. Everything is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  host write strobe. Honoured only in IDLE.
- `wr_sel`  in  1  write target: 0 = string buffer, 1 = pattern buffer.
- `wr_data`  in  8  character to append.
- `start`  in  1  one-cycle request to run a transaction.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the transaction ends.
- `res_match`  out  1  captured `match`. Held until the next `done`.
- `res_index`  out  5  captured `match_index`. Held until the next `done`.
- `res_timeout`  out  1  high if the last transaction timed out.
- `chardata`  out  8  character to the SME.
- `isstring`  out  1  qualifies `chardata` as a string char.
- `ispattern`  out  1  qualifies `chardata` as a pattern char.
- `match`  in  1  from the SME.
- `match_index`  in  5  from the SME.
- `valid`  in  1  from the SME. Result qualifier.

## Operation
- **FSM states:** IDLE, SEND_STR, SEND_PAT, WAIT, DONE.
- **Buffers:**
  - `str_len` is 6 bits, 0..32. `pat_len` is 4 bits, 0..8.
  - Writes append at index `len`.
  - A write when `len` is at its maximum is dropped and the buffer is left unchanged.
- **String buffer:**
  - `str_new` flag is set by any string write. It is cleared when the string has been sent.
  - The first string write after `str_new` was cleared resets `str_len` to 0 before appending, so a new string replaces the old one.
  - If `str_new` is 0 at start, the previous string is not resent; the SME retains it.
- **Pattern buffer:** `pat_len` is cleared in DONE. Every transaction needs a freshly written pattern.
- **IDLE:**
  - `start` is accepted only if `pat_len` > 0 and `str_len` > 0.
  - If accepted and `str_new` = 1, go to SEND_STR. If accepted and `str_new` = 0, go to SEND_PAT.
  - A non-accepted `start` is ignored: no `busy`, no `done`.
  - If `wr_en` and `start` occur in the same cycle, the write is applied first and `start` is evaluated against the post-write lengths.
- **SEND_STR:**
  - Drive `chardata` = `str[i]` with `isstring` = 1, for i = 0..`str_len`-1, one char per cycle.
  - After the last char, go to SEND_PAT and clear `str_new`.
- **SEND_PAT:**
  - Drive `pat[j]` with `ispattern` = 1, for j = 0..`pat_len`-1.
  - After the last char, go to WAIT.
- **WAIT:**
  - `isstring` = `ispattern` = 0 and `chardata` = 0.
  - On `valid` = 1: capture `match` and `match_index`, set `res_timeout` = 0, go to DONE.
  - A 10-bit wait counter increments every WAIT cycle. When it reaches `TIMEOUT` with no `valid`: set `res_timeout` = 1 and `res_match` = 0, leave `res_index` unchanged, go to DONE.
- **DONE:** `done` = 1 for one cycle. Clear `pat_len` and the wait counter. Go to IDLE.
- **Stray `valid`:** `valid` outside WAIT is ignored.
- **Writes while busy:** ignored in every state except IDLE.
- **`isstring`/`ispattern`:** never both high in the same cycle.
- **Reset:**
  - Asserting `reset` at any time, including mid-stream, returns the FSM to IDLE.
  - It clears `str_len`, `pat_len`, `str_new` and the wait counter.
  - It forces all outputs to 0: `chardata`, `isstring`, `ispattern`, `busy`, `done`, `res_match`, `res_index`, `res_timeout`.
  - Buffer contents need not be cleared.

## Timing
- All outputs are registered.
- `start` is sampled at edge T.
- `busy` rises and the first char appears after edge T, so both are visible in cycle T+1.
- A string of N chars occupies cycles T+1..T+N.
- A pattern of M chars occupies cycles T+N+1..T+N+M. With no resend, the pattern occupies T+1..T+M.
- WAIT starts in the cycle after the last pattern char. `ispattern` is low in that cycle.
- If `valid` is sampled high in cycle V, then in cycle V+1: `res_*` are updated, `done` = 1 and `busy` = 0.
- The next `start` can be accepted in cycle V+2.
- Minimum transaction with N = 1, M = 1 and `valid` in the first WAIT cycle: `done` in cycle T+4.

## Test plan
- Write "abc" as the string and "b" as the pattern, then `start`:
  - `chardata` = 61, 62, 63 with `isstring` high in cycles T+1..T+3.
  - 62 with `ispattern` high in cycle T+4.
  - Model returns `valid`, `match` = 1, `match_index` = 1 in cycle T+6 → `done` in T+7 with `res_match` = 1, `res_index` = 1, `res_timeout` = 0.
- Second transaction with pattern "c" only and no new string write:
  - No `isstring` cycles; `ispattern` in T+1.
  - `valid` returned with index 2 → `res_index` = 2.
- Write 33 string chars and 9 pattern chars:
  - Exactly 32 `isstring` cycles and 8 `ispattern` cycles are emitted.
  - The extra chars are never sent.
- `start` with `pat_len` = 0 → `busy` stays 0 and no `done` for 10 cycles. Pulse `valid` in IDLE → results unchanged.
- SME never asserts `valid` (set `TIMEOUT` = 20) → `done` after 20 WAIT cycles with `res_timeout` = 1 and `res_match` = 0.
- Assert `reset` in the middle of SEND_STR:
  - All outputs are 0 the same cycle, without waiting for a clock edge.
  - `start` is ignored afterwards until a new string and pattern are written.

Source files
------------

// File: rtl/sme_driver_if.sv
// Host and SME signal bundle for sme_driver.
// The master modport is the driver's view; slave is the host/SME side.
interface sme_driver_if;
    logic       wr_en;
    logic       wr_sel;
    logic [7:0] wr_data;
    logic       start;
    logic       busy;
    logic       done;
    logic       res_match;
    logic [4:0] res_index;
    logic       res_timeout;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       match;
    logic [4:0] match_index;
    logic       valid;

    modport master (
        input  wr_en, wr_sel, wr_data, start, match, match_index, valid,
        output busy, done, res_match, res_index, res_timeout, chardata, isstring, ispattern
    );

    modport slave (
        output wr_en, wr_sel, wr_data, start, match, match_index, valid,
        input  busy, done, res_match, res_index, res_timeout, chardata, isstring, ispattern
    );
endinterface

// File: rtl/sme_driver.sv
// Host-side transmitter for the string-matching engine: buffers a string and a pattern,
// streams them on chardata/isstring/ispattern and captures the engine's result.
module sme_driver #(
    parameter int unsigned STR_MAX = 32,
    parameter int unsigned PAT_MAX = 8,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic         clk,
    input  logic         reset,
    sme_driver_if.master bus
);
    localparam int unsigned SLW = $clog2(STR_MAX + 1);
    localparam int unsigned PLW = $clog2(PAT_MAX + 1);
    localparam int unsigned SIW = $clog2(STR_MAX);
    localparam int unsigned PIW = $clog2(PAT_MAX);
    localparam logic [SLW-1:0] StrMax   = SLW'(STR_MAX);
    localparam logic [PLW-1:0] PatMax   = PLW'(PAT_MAX);
    localparam logic [9:0]     WaitLast = 10'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StSendStr, StSendPat, StWait, StDone} state_e;

    state_e         state;
    logic [7:0]     str_mem [STR_MAX];
    logic [7:0]     pat_mem [PAT_MAX];
    logic [SLW-1:0] str_len;
    logic [PLW-1:0] pat_len;
    logic           str_new;
    logic [SIW-1:0] idx;
    logic [9:0]     wait_cnt;

    logic       busy_q, done_q, res_match_q, res_timeout_q, isstring_q, ispattern_q;
    logic [4:0] res_index_q;
    logic [7:0] chardata_q;

    logic           str_wr, pat_wr, str_wr_ok, pat_wr_ok, str_new_post, accept;
    logic [SLW-1:0] str_wr_idx, str_len_post, str_next;
    logic [PLW-1:0] pat_len_post, pat_next;
    logic [7:0]     str_first, pat_first;

    // A same-cycle write lands before start is judged, so the first char may come from wr_data.
    always_comb begin
        str_wr       = bus.wr_en && (state == StIdle) && !bus.wr_sel;
        pat_wr       = bus.wr_en && (state == StIdle) && bus.wr_sel;
        str_wr_idx   = str_new ? str_len : '0;
        str_wr_ok    = str_wr && (str_wr_idx < StrMax);
        str_len_post = str_wr_ok ? str_wr_idx + SLW'(1) : str_len;
        str_new_post = str_new | str_wr;
        pat_wr_ok    = pat_wr && (pat_len < PatMax);
        pat_len_post = pat_wr_ok ? pat_len + PLW'(1) : pat_len;
        accept       = bus.start && (state == StIdle) && (str_len_post != '0) &&
                       (pat_len_post != '0);
        str_first    = (str_wr_ok && (str_wr_idx == '0)) ? bus.wr_data : str_mem[0];
        pat_first    = (pat_wr_ok && (pat_len == '0)) ? bus.wr_data : pat_mem[0];
        str_next     = SLW'(idx) + SLW'(1);
        pat_next     = PLW'(idx[PIW-1:0]) + PLW'(1);
    end

    always_ff @(posedge clk) begin
        if (str_wr_ok) str_mem[str_wr_idx[SIW-1:0]] <= bus.wr_data;
        if (pat_wr_ok) pat_mem[pat_len[PIW-1:0]] <= bus.wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= StIdle;
            str_len       <= '0;
            pat_len       <= '0;
            str_new       <= 1'b0;
            idx           <= '0;
            wait_cnt      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            res_match_q   <= 1'b0;
            res_index_q   <= '0;
            res_timeout_q <= 1'b0;
            chardata_q    <= '0;
            isstring_q    <= 1'b0;
            ispattern_q   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    str_len <= str_len_post;
                    pat_len <= pat_len_post;
                    str_new <= str_new_post;
                    idx     <= '0;
                    if (accept) begin
                        busy_q <= 1'b1;
                        if (str_new_post) begin
                            state      <= StSendStr;
                            chardata_q <= str_first;
                            isstring_q <= 1'b1;
                        end else begin
                            state       <= StSendPat;
                            chardata_q  <= pat_first;
                            ispattern_q <= 1'b1;
                        end
                    end
                end
                StSendStr: begin
                    if (str_next < str_len) begin
                        idx        <= str_next[SIW-1:0];
                        chardata_q <= str_mem[str_next[SIW-1:0]];
                    end else begin
                        state       <= StSendPat;
                        str_new     <= 1'b0;
                        idx         <= '0;
                        isstring_q  <= 1'b0;
                        ispattern_q <= 1'b1;
                        chardata_q  <= pat_mem[0];
                    end
                end
                StSendPat: begin
                    if (pat_next < pat_len) begin
                        idx        <= SIW'(pat_next[PIW-1:0]);
                        chardata_q <= pat_mem[pat_next[PIW-1:0]];
                    end else begin
                        state       <= StWait;
                        ispattern_q <= 1'b0;
                        chardata_q  <= '0;
                        wait_cnt    <= '0;
                    end
                end
                StWait: begin
                    if (bus.valid) begin
                        res_match_q   <= bus.match;
                        res_index_q   <= bus.match_index;
                        res_timeout_q <= 1'b0;
                        done_q        <= 1'b1;
                        busy_q        <= 1'b0;
                        state         <= StDone;
                    end else if (wait_cnt == WaitLast) begin
                        // Abandon: index keeps its previous value.
                        res_timeout_q <= 1'b1;
                        res_match_q   <= 1'b0;
                        done_q        <= 1'b1;
                        busy_q        <= 1'b0;
                        state         <= StDone;
                    end else begin
                        wait_cnt <= wait_cnt + 10'd1;
                    end
                end
                StDone: begin
                    done_q   <= 1'b0;
                    pat_len  <= '0;
                    wait_cnt <= '0;
                    state    <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.res_match   = res_match_q;
    assign bus.res_index   = res_index_q;
    assign bus.res_timeout = res_timeout_q;
    assign bus.chardata    = chardata_q;
    assign bus.isstring    = isstring_q;
    assign bus.ispattern   = ispattern_q;
endmodule

// File: tb/tb_sme_driver.sv
// Self-checking bench for sme_driver: directed scenarios plus randomized transactions
// compared against a queue-based model of the buffers and the expected char stream.
module tb_sme_driver;
    localparam int TO = 20;

    logic clk;
    logic reset;
    sme_driver_if bus();

    sme_driver #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks;
    int errors;

    logic [7:0] m_str[$];
    logic [7:0] m_pat[$];
    bit         m_str_new;
    logic       m_res_match;
    logic [4:0] m_res_index;
    logic       m_res_to;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic void model_write(input bit sel, input logic [7:0] d);
        if (!sel) begin
            if (!m_str_new) m_str.delete();
            m_str_new = 1'b1;
            if (m_str.size() < 32) m_str.push_back(d);
        end else if (m_pat.size() < 8) begin
            m_pat.push_back(d);
        end
    endfunction

    function automatic void model_reset();
        m_str.delete();
        m_pat.delete();
        m_str_new   = 1'b0;
        m_res_match = 1'b0;
        m_res_index = '0;
        m_res_to    = 1'b0;
    endfunction

    task automatic write_char(input bit sel, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
        model_write(sel, d);
    endtask

    // Start (optionally with a same-cycle pattern write) and follow the whole transaction.
    // delay = WAIT cycles before valid; delay >= TO means the SME never answers.
    task automatic run_txn(input int delay, input logic m, input logic [4:0] ix,
                           input bit wr_pat, input logic [7:0] pd);
        logic [9:0]  exp_q[$];
        logic [11:0] obs;
        logic [11:0] expv;
        logic [19:0] obs_d;
        logic [19:0] exp_d;
        bit          answered;
        answered = 1'b0;
        if (wr_pat) begin
            bus.wr_en   = 1'b1;
            bus.wr_sel  = 1'b1;
            bus.wr_data = pd;
            model_write(1'b1, pd);
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        if (m_str_new) foreach (m_str[k]) exp_q.push_back({2'b10, m_str[k]});
        foreach (m_pat[k]) exp_q.push_back({2'b01, m_pat[k]});
        m_str_new = 1'b0;
        foreach (exp_q[k]) begin
            obs  = {bus.busy, bus.done, bus.isstring, bus.ispattern, bus.chardata};
            expv = {2'b10, exp_q[k]};
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL stream[%0d] busy/done/isstr/ispat/char: got %h required %h",
                         k, obs, expv);
            end
            @(negedge clk);
        end
        for (int w = 1; w <= TO; w++) begin
            obs = {bus.busy, bus.done, bus.isstring, bus.ispattern, bus.chardata};
            checks++;
            if (obs !== 12'h800) begin
                errors++;
                $display("FAIL wait[%0d] busy/done/isstr/ispat/char: got %h required 800", w, obs);
            end
            if (delay < TO && w == delay + 1) begin
                bus.valid       = 1'b1;
                bus.match       = m;
                bus.match_index = ix;
                @(negedge clk);
                bus.valid       = 1'b0;
                bus.match       = 1'($urandom);
                bus.match_index = 5'($urandom);
                answered        = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (answered) begin
            m_res_match = m;
            m_res_index = ix;
            m_res_to    = 1'b0;
        end else begin
            m_res_match = 1'b0;
            m_res_to    = 1'b1;
        end
        m_pat.delete();
        obs_d = {bus.busy, bus.done, bus.isstring, bus.ispattern, bus.chardata,
                 bus.res_match, bus.res_index, bus.res_timeout};
        exp_d = {4'b0100, 8'h00, m_res_match, m_res_index, m_res_to};
        checks++;
        if (obs_d !== exp_d) begin
            errors++;
            $display("FAIL done cycle busy/done/str/pat/char/match/index/timeout: got %h required %h",
                     obs_d, exp_d);
        end
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++;
            $display("FAIL after done busy/done: got %b required 00", {bus.busy, bus.done});
        end
    endtask

    task automatic test_reset();
        bus.wr_en = 0; bus.wr_sel = 0; bus.wr_data = 0; bus.start = 0;
        bus.match = 0; bus.match_index = 0; bus.valid = 0;
        reset = 1'b0;
        model_reset();
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({bus.chardata, bus.isstring, bus.ispattern, bus.busy, bus.done, bus.res_match,
             bus.res_index, bus.res_timeout} !== 20'h0) begin
            errors++;
            $display("FAIL reset outputs: got nonzero %h required 0",
                     {bus.chardata, bus.isstring, bus.ispattern, bus.busy, bus.done});
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.isstring, bus.ispattern} !== 4'b0) begin
            errors++;
            $display("FAIL post-reset idle: got %b required 0000",
                     {bus.busy, bus.done, bus.isstring, bus.ispattern});
        end
    endtask

    task automatic test_basic();
        write_char(0, 8'h61); write_char(0, 8'h62); write_char(0, 8'h63);
        write_char(1, 8'h62);
        run_txn(1, 1'b1, 5'd1, 0, 8'h00);
    endtask

    task automatic test_no_resend();
        write_char(1, 8'h63);
        run_txn(0, 1'b1, 5'd2, 0, 8'h00);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 33; i++) write_char(0, 8'($urandom));
        for (int i = 0; i < 9; i++) write_char(1, 8'($urandom));
        run_txn(2, 1'b0, 5'd17, 0, 8'h00);
    endtask

    task automatic test_no_pattern();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus.valid       = 1'b1;
                bus.match       = ~m_res_match;
                bus.match_index = ~m_res_index;
            end
            if (i == 4) bus.valid = 1'b0;
            checks++;
            if ({bus.busy, bus.done} !== 2'b00) begin
                errors++;
                $display("FAIL no-pattern start busy/done[%0d]: got %b required 00",
                         i, {bus.busy, bus.done});
            end
            @(negedge clk);
        end
        checks++;
        if ({bus.res_match, bus.res_index, bus.res_timeout} !== {m_res_match, m_res_index, m_res_to})
        begin
            errors++;
            $display("FAIL stray valid results: got %h required %h",
                     {bus.res_match, bus.res_index, bus.res_timeout},
                     {m_res_match, m_res_index, m_res_to});
        end
    endtask

    task automatic test_timeout();
        write_char(1, 8'h5a);
        run_txn(TO, 1'b1, 5'd9, 0, 8'h00);
    endtask

    task automatic test_same_cycle();
        // Pattern buffer is empty; the write in the start cycle must make start valid.
        run_txn(0, 1'b1, 5'd4, 1, 8'($urandom));
    endtask

    task automatic test_random();
        int n;
        bit last_same;
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                n = $urandom_range(1, 34);
                for (int i = 0; i < n; i++) write_char(0, 8'($urandom));
            end
            n         = $urandom_range(1, 9);
            last_same = 1'($urandom_range(0, 1));
            for (int i = 0; i < n - int'(last_same); i++) write_char(1, 8'($urandom));
            run_txn($urandom_range(0, 24), 1'($urandom), 5'($urandom), last_same, 8'($urandom));
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) write_char(0, 8'($urandom));
        write_char(1, 8'h11); write_char(1, 8'h22);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if ({bus.busy, bus.isstring, bus.chardata} !== {2'b11, m_str[0]}) begin
            errors++;
            $display("FAIL reset-mid first char: got %h required %h",
                     {bus.busy, bus.isstring, bus.chardata}, {2'b11, m_str[0]});
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.chardata, bus.isstring, bus.ispattern, bus.busy, bus.done, bus.res_match,
             bus.res_index, bus.res_timeout} !== 20'h0) begin
            errors++;
            $display("FAIL async reset mid-stream: got %h required 0",
                     {bus.chardata, bus.isstring, bus.ispattern, bus.busy, bus.done,
                      bus.res_match, bus.res_index, bus.res_timeout});
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) write_char(1, 8'h33);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            for (int i = 0; i < 10; i++) begin
                checks++;
                if ({bus.busy, bus.done} !== 2'b00) begin
                    errors++;
                    $display("FAIL start after reset pass%0d[%0d]: got %b required 00",
                             pass, i, {bus.busy, bus.done});
                end
                @(negedge clk);
            end
        end
        write_char(0, 8'h78); write_char(0, 8'h79);
        run_txn(0, 1'b1, 5'd3, 0, 8'h00);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_no_resend();
        test_overflow();
        test_no_pattern();
        test_timeout();
        test_same_cycle();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
